mul_ctrl: RTL
=============

Name: mul_ctrl

Overview:
- Issue/finish wrapper around the unsigned combinational 32x32 multiplier (mul32x32).
- Accepts RV32M-style multiply requests (MUL, MULH, MULHSU, MULHU) over a valid/ready handshake.
- Converts the operands to unsigned magnitudes and drives them to the external multiplier instance.
- Captures the 64-bit unsigned product, restores the sign, selects the low or high word and returns it with a tag over a second valid/ready handshake. Two-stage pipeline, one result per cycle sustained.

Parameters:
TAG_W, 5, width of the request tag (e.g. destination register index) carried alongside each operation.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-high
flush  input  1  kill all in-flight operations (synchronous)
in_valid  input  1  request valid
in_ready  output  1  block can accept a request this cycle
in_op  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
in_a  input  32  operand a (rs1)
in_b  input  32  operand b (rs2)
in_tag  input  TAG_W  request tag
mul_a  output  32  magnitude of a, to mul32x32 .a
mul_b  output  32  magnitude of b, to mul32x32 .b
mul_p  input  64  unsigned product from mul32x32 .p, combinational from mul_a/mul_b
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_result  output  32  selected result word
out_tag  output  TAG_W  tag of the result

Behaviour:
- Reset and interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: s1_valid=0, s2_valid=0, so out_valid=0 and in_ready=1 after reset.
- All datapath registers reset to 0: out_result=0, out_tag=0, mul_a=0, mul_b=0.
- Sign rules:
  - sa = a[31] for MULH and MULHSU, else 0.
  - sb = b[31] for MULH only, else 0.
  - |x| = sx ? (~x+1) : x, 32-bit unsigned. |0x80000000| = 0x80000000, with no overflow.
  - neg = sa ^ sb.
- Stage S1 (registered on accept): abs_a, abs_b, neg, hi = (op != 00), tag.
  - mul_a = abs_a and mul_b = abs_b, driven straight from the S1 registers.
- Multiplier: combinational between S1 and S2.
- Stage S2 (registered on S1 advance):
  - prod = neg ? (~mul_p + 1) : mul_p, 64-bit two's complement.
  - result = hi ? prod[63:32] : prod[31:0].
  - S2 also registers the tag.
  - out_result and out_tag come straight from the S2 registers.
- MUL: the low word is identical for signed and unsigned interpretations, so sa = sb = 0 is correct.
- Latency: request accepted in cycle N gives out_valid=1 in cycle N+2 if the output is not stalled.
- Handshake:
  - s2_adv = s1_valid & (~s2_valid | out_ready).
  - in_ready = ~s1_valid | s2_adv.
  - An accept occurs when in_valid & in_ready.
  - Consuming S2 and loading S2 in the same cycle is allowed, giving back-to-back throughput of 1 per cycle.
  - While out_valid=1 and out_ready=0: out_result and out_tag hold stable, S2 holds, and S1 holds if it is full; in_ready=0 once both stages are full.
  - A new request is never accepted into a full, non-advancing S1.
- Simultaneous events:
  - S2 being drained while S1 advances loads S2 with S1 data.
  - S1 advancing while accepting reloads S1 with the new request.
- flush:
  - Clears s1_valid and s2_valid next cycle.
  - in_ready is forced to 0 during the flush cycle, so a request presented that cycle is not accepted.
  - Datapath registers are not cleared.
- rst has priority over flush. rst mid-operation discards all in-flight results; no out_valid is produced for them.
- out_valid must not depend combinationally on out_ready.
- in_ready may depend combinationally on out_ready.

Test Plan:
- Reset then a single MUL, a=7, b=0xFFFFFFFD (-3), tag=3 -> out_valid exactly 2 cycles after accept, out_result=0xFFFFFFEB, out_tag=3.
- MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH a=b=0xFFFFFFFF -> 0x00000000; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- MULH a=b=0x80000000 -> mul_a=mul_b=0x80000000, out_result=0x40000000; MULH a=0x80000000, b=1 -> 0xFFFFFFFF.
- Back-to-back stream of 8 requests (tags 0..7) with out_ready=1 -> 8 consecutive out_valid cycles, in order, in_ready held at 1.
- Hold out_ready=0 for 5 cycles with 3 requests offered -> in_ready drops after 2 accepts and out_result/out_tag stay stable; releasing out_ready drains tags in order with no loss or duplicate.
- Assert flush (or rst) with both stages full -> out_valid=0 next cycle and no stale results appear; a request offered in the flush cycle is not accepted, and the next request completes normally.

Source files
------------

// File: rtl/mul_ctrl.sv
// rtl/mul_ctrl.sv - two-stage issue/finish wrapper around an external unsigned 32x32 multiplier
module mul_ctrl #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    input  logic [63:0]      mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } op_e;

    logic             s1_valid;
    logic [31:0]      s1_a;
    logic [31:0]      s1_b;
    logic             s1_neg;
    logic             s1_hi;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid;
    logic [31:0]      s2_result;
    logic [TAG_W-1:0] s2_tag;

    logic             sa;
    logic             sb;
    logic [31:0]      abs_a;
    logic [31:0]      abs_b;
    logic [63:0]      prod;
    logic [31:0]      result;
    logic             s2_adv;
    logic             accept;

    // MUL keeps both operands unsigned: the low word is sign-agnostic.
    always_comb begin
        sa     = 1'b0;
        sb     = 1'b0;
        abs_a  = in_a;
        abs_b  = in_b;
        prod   = mul_p;
        result = mul_p[31:0];
        if (in_op == OP_MULH || in_op == OP_MULHSU) begin
            sa = in_a[31];
        end
        if (in_op == OP_MULH) begin
            sb = in_b[31];
        end
        if (sa) begin
            abs_a = ~in_a + 32'd1;
        end
        if (sb) begin
            abs_b = ~in_b + 32'd1;
        end
        if (s1_neg) begin
            prod = ~mul_p + 64'd1;
        end
        result = s1_hi ? prod[63:32] : prod[31:0];
    end

    assign s2_adv   = s1_valid & (~s2_valid | out_ready);
    assign in_ready = ~flush & (~s1_valid | s2_adv);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_neg    <= 1'b0;
            s1_hi     <= 1'b0;
            s1_tag    <= '0;
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_tag    <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_a     <= abs_a;
                s1_b     <= abs_b;
                s1_neg   <= sa ^ sb;
                s1_hi    <= (in_op != OP_MUL);
                s1_tag   <= in_tag;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end

            if (s2_adv) begin
                s2_valid  <= 1'b1;
                s2_result <= result;
                s2_tag    <= s1_tag;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    assign mul_a      = s1_a;
    assign mul_b      = s1_b;
    assign out_valid  = s2_valid;
    assign out_result = s2_result;
    assign out_tag    = s2_tag;

endmodule
